// File: rtl/vga_pkg.sv
// Shared frame geometry, port widths and controller state encoding for the
// VGA pixel-write path.
package vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;
   localparam int PACE_W   = 6;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last_granted+1 upward (mod N)
// and returns the first requester as a one-hot grant plus its index.
module rr_arbiter
   import vga_pkg::*;
#(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_granted_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] winner_o,
   output logic             valid_o
);

   function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] last, input int step);
      return IDX_W'((int'(last) + step) % N);
   endfunction

   always_comb begin
      grant_o  = '0;
      winner_o = '0;
      valid_o  = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!valid_o && req_i[slot(last_granted_i, k)]) begin
            valid_o                           = 1'b1;
            winner_o                          = slot(last_granted_i, k);
            grant_o[slot(last_granted_i, k)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_write_arbiter.sv
// Owns the VGA adapter write port: round-robin pixel writes from NUM_REQ
// clients, pre-empted by a built-in full-screen clear sweep.
module vga_write_arbiter
   import vga_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int SCREEN_W = vga_pkg::SCREEN_W,
   parameter int SCREEN_H = vga_pkg::SCREEN_H,
   parameter int PACE     = 0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          clear_start,
   input  logic [COLOUR_W-1:0]           clear_colour,
   output logic                          clear_busy,
   output logic                          clear_done,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [X_W*NUM_REQ-1:0]        req_x,
   input  logic [Y_W*NUM_REQ-1:0]        req_y,
   input  logic [COLOUR_W*NUM_REQ-1:0]   req_colour,
   output logic [NUM_REQ-1:0]            grant,
   output logic [X_W-1:0]                x_out,
   output logic [Y_W-1:0]                y_out,
   output logic [COLOUR_W-1:0]           colour_out,
   output logic                          plot
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [X_W-1:0]    X_LAST   = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(SCREEN_H - 1);
   localparam logic [X_W:0]      X_LIM    = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0]      Y_LIM    = (Y_W + 1)'(SCREEN_H);
   localparam logic [PACE_W-1:0] PACE_V   = PACE_W'(PACE);
   localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);

   logic [X_W-1:0]      cli_x   [NUM_REQ];
   logic [Y_W-1:0]      cli_y   [NUM_REQ];
   logic [COLOUR_W-1:0] cli_col [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign cli_x[gi]   = req_x[gi*X_W +: X_W];
      assign cli_y[gi]   = req_y[gi*Y_W +: Y_W];
      assign cli_col[gi] = req_colour[gi*COLOUR_W +: COLOUR_W];
   end

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [X_W-1:0]      x_cnt_q, x_cnt_d;
   logic [Y_W-1:0]      y_cnt_q, y_cnt_d;
   logic [PACE_W-1:0]   pace_q, pace_d;
   logic [COLOUR_W-1:0] fill_q, fill_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic [COLOUR_W-1:0] col_q, col_d;
   logic                plot_q, plot_d;
   logic                done_q, done_d;

   logic [NUM_REQ-1:0]  arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_valid;
   logic                arb_en;
   logic [X_W-1:0]      sel_x;
   logic [Y_W-1:0]      sel_y;
   logic [COLOUR_W-1:0] sel_col;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req_i          (req),
      .last_granted_i (last_q),
      .grant_o        (arb_grant),
      .winner_o       (arb_idx),
      .valid_o        (arb_valid)
   );

   // A clear request in ARB pre-empts the arbiter in the very same cycle.
   assign arb_en  = (state_q == ARB) && !clear_start;
   assign grant   = arb_en ? arb_grant : '0;

   assign sel_x   = cli_x[arb_idx];
   assign sel_y   = cli_y[arb_idx];
   assign sel_col = cli_col[arb_idx];

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      pace_d  = pace_q;
      fill_d  = fill_q;
      x_d     = x_q;
      y_d     = y_q;
      col_d   = col_q;
      plot_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ARB: begin
            if (clear_start) begin
               fill_d  = clear_colour;
               x_cnt_d = '0;
               y_cnt_d = '0;
               pace_d  = '0;
               state_d = CLEAR;
            end else if (arb_valid) begin
               x_d    = sel_x;
               y_d    = sel_y;
               col_d  = sel_col;
               // Off-screen pixels are consumed but never reach the adapter.
               plot_d = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
               last_d = arb_idx;
            end
         end

         CLEAR: begin
            if (pace_q == '0) begin
               x_d    = x_cnt_q;
               y_d    = y_cnt_q;
               col_d  = fill_q;
               plot_d = 1'b1;
               pace_d = PACE_V;
               if (x_cnt_q == X_LAST) begin
                  x_cnt_d = '0;
                  if (y_cnt_q == Y_LAST) begin
                     y_cnt_d = '0;
                     done_d  = 1'b1;
                     state_d = ARB;
                  end else begin
                     y_cnt_d = y_cnt_q + 1'b1;
                  end
               end else begin
                  x_cnt_d = x_cnt_q + 1'b1;
               end
            end else begin
               pace_d = pace_q - 1'b1;
            end
         end

         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ARB;
         last_q  <= LAST_RST;
         x_cnt_q <= '0;
         y_cnt_q <= '0;
         pace_q  <= '0;
         fill_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         col_q   <= '0;
         plot_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;
         pace_q  <= pace_d;
         fill_q  <= fill_d;
         x_q     <= x_d;
         y_q     <= y_d;
         col_q   <= col_d;
         plot_q  <= plot_d;
         done_q  <= done_d;
      end
   end

   assign clear_busy = (state_q == CLEAR);
   assign clear_done = done_q;
   assign x_out      = x_q;
   assign y_out      = y_q;
   assign colour_out = col_q;
   assign plot       = plot_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Randomised bench for vga_write_arbiter with a cycle-level behavioural model
// plus directed literal checks of arbitration, range gating and the clear sweep.
module tb_vga_write_arbiter;

   localparam int NR = 3;
   localparam int W  = 160;
   localparam int H  = 120;
   localparam int P  = 1;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            clear_start = 1'b0;
   logic [2:0]      clear_colour = '0;
   logic            clear_busy;
   logic            clear_done;
   logic [NR-1:0]   req = '0;
   logic [8*NR-1:0] req_x = '0;
   logic [7*NR-1:0] req_y = '0;
   logic [3*NR-1:0] req_colour = '0;
   logic [NR-1:0]   grant;
   logic [7:0]      x_out;
   logic [6:0]      y_out;
   logic [2:0]      colour_out;
   logic            plot;

   always #5 clock = ~clock;

   vga_write_arbiter #(
      .NUM_REQ  (NR),
      .SCREEN_W (W),
      .SCREEN_H (H),
      .PACE     (P)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .clear_start  (clear_start),
      .clear_colour (clear_colour),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .req          (req),
      .req_x        (req_x),
      .req_y        (req_y),
      .req_colour   (req_colour),
      .grant        (grant),
      .x_out        (x_out),
      .y_out        (y_out),
      .colour_out   (colour_out),
      .plot         (plot)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Round-robin rule: first requester at or after last+1, wrapping.
   function automatic int rr_pick(input logic [NR-1:0] r, input int last);
      for (int s = 1; s <= NR; s++) begin
         if (r[(last + s) % NR]) return (last + s) % NR;
      end
      return -1;
   endfunction

   // Model state: what the DUT outputs must be in the current cycle.
   bit          model_on = 1'b0;
   bit          m_clear = 1'b0;
   int          m_r = 0;
   logic [2:0]  m_col = '0;
   int          m_last = NR - 1;
   logic [7:0]  m_x = '0;
   logic [6:0]  m_y = '0;
   logic [2:0]  m_c = '0;
   logic        m_plot = 1'b0;
   logic        m_done = 1'b0;
   logic [NR-1:0] g_q = '0;
   int          w_m;
   int          k_m;
   logic [NR-1:0] eg;

   initial begin
      forever begin
         @(negedge clock);
         w_m = -1;
         eg  = '0;
         if (!m_clear && !clear_start) w_m = rr_pick(req, m_last);
         if (w_m >= 0) eg[w_m] = 1'b1;
         if (model_on) begin
            chk("grant", 32'(grant), 32'(eg));
            chk("port", 32'({x_out, y_out, colour_out, plot}), 32'({m_x, m_y, m_c, m_plot}));
            chk("status", 32'({clear_busy, clear_done}), 32'({m_clear, m_done}));
         end
         g_q = grant;
         if (reset) begin
            m_clear  = 1'b0;
            m_last   = NR - 1;
            m_x      = '0;
            m_y      = '0;
            m_c      = '0;
            m_plot   = 1'b0;
            m_done   = 1'b0;
            model_on = 1'b1;
         end else if (m_clear) begin
            m_plot = 1'b0;
            m_done = 1'b0;
            if (m_r % (P + 1) == 0) begin
               k_m    = m_r / (P + 1);
               m_x    = 8'(k_m % W);
               m_y    = 7'(k_m / W);
               m_c    = m_col;
               m_plot = 1'b1;
               if (k_m == W * H - 1) begin
                  m_done  = 1'b1;
                  m_clear = 1'b0;
               end
            end
            m_r++;
         end else begin
            m_plot = 1'b0;
            m_done = 1'b0;
            if (clear_start) begin
               m_clear = 1'b1;
               m_r     = 0;
               m_col   = clear_colour;
            end else if (w_m >= 0) begin
               m_x    = req_x[w_m*8 +: 8];
               m_y    = req_y[w_m*7 +: 7];
               m_c    = req_colour[w_m*3 +: 3];
               m_plot = (int'(m_x) < W) && (int'(m_y) < H);
               m_last = w_m;
            end
         end
      end
   end

   // Clients obey the handshake: only a granted or idle client changes its pixel.
   task automatic drive_random();
      for (int i = 0; i < NR; i++) begin
         if (!req[i] || g_q[i]) begin
            req[i]              = ($urandom_range(0, 3) != 0);
            req_x[i*8 +: 8]     = 8'($urandom_range(0, 175));
            req_y[i*7 +: 7]     = 7'($urandom_range(0, 127));
            req_colour[i*3 +: 3] = 3'($urandom_range(0, 7));
         end
      end
   endtask

   logic [NR-1:0] fair [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   int plots;
   int dones;
   int done_off;

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Single client (10,20,5) on client 1
      req = 3'b010;
      req_x[15:8] = 8'd10;
      req_y[13:7] = 7'd20;
      req_colour[5:3] = 3'b101;
      @(negedge clock);
      chk("single_grant", 32'(grant), 32'(3'b010));
      @(posedge clock); #1 req = '0;
      @(negedge clock);
      chk("single_port", 32'({x_out, y_out, colour_out, plot}), 32'({8'd10, 7'd20, 3'd5, 1'b1}));

      // Fairness from a fresh reset
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      req = '1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clock);
         chk("fair_grant", 32'(grant), 32'(fair[j]));
         @(posedge clock); #1;
      end
      req = '0;

      // Out-of-range pixel consumed but not plotted, then a corner pixel
      req = 3'b001;
      req_x[7:0] = 8'd160;
      req_y[6:0] = 7'd5;
      @(negedge clock);
      chk("oor_grant", 32'(grant), 32'(3'b001));
      @(posedge clock); #1;
      req_x[7:0] = 8'd159;
      req_y[6:0] = 7'd119;
      @(negedge clock);
      chk("oor_plot", 32'(plot), 32'(1'b0));
      chk("corner_grant", 32'(grant), 32'(3'b001));
      @(posedge clock); #1 req = '0;
      @(negedge clock);
      chk("corner_port", 32'({x_out, y_out, plot}), 32'({8'd159, 7'd119, 1'b1}));

      // Random client traffic
      repeat (1500) begin
         @(posedge clock); #1;
         drive_random();
      end

      // Full clear with all clients requesting; a second start mid-sweep is ignored
      @(posedge clock); #1;
      req = '1;
      clear_start = 1'b1;
      clear_colour = 3'b010;
      @(negedge clock);
      chk("clr_accept_grant", 32'(grant), 32'(0));
      plots = 0;
      dones = 0;
      done_off = 0;
      for (int n = 1; n <= 40000 && (done_off == 0 || n < done_off + 4); n++) begin
         @(posedge clock); #1;
         clear_start = (n == 1000);
         if (n == 1000) clear_colour = 3'b111;
         drive_random();
         @(negedge clock);
         if (plot && (clear_busy || clear_done)) plots++;
         if (clear_done) begin
            dones++;
            if (done_off == 0) done_off = n;
         end
      end
      chk("clr_done_offset", 32'(done_off), 32'(38400));
      chk("clr_plots", 32'(plots), 32'(19200));
      chk("clr_done_pulses", 32'(dones), 32'(1));

      // Reset at pixel 500 of a clear aborts it
      @(posedge clock); #1;
      clear_start = 1'b1;
      clear_colour = 3'b110;
      @(negedge clock);
      plots = 0;
      for (int n = 0; n < 3000 && plots < 500; n++) begin
         @(posedge clock); #1;
         clear_start = 1'b0;
         drive_random();
         @(negedge clock);
         if (plot && clear_busy) plots++;
      end
      chk("mid_plots", 32'(plots), 32'(500));
      @(posedge clock); #1;
      reset = 1'b1;
      req = '1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_port", 32'({x_out, y_out, colour_out, plot}), 32'(0));
      chk("rst_status", 32'({clear_busy, clear_done}), 32'(0));
      chk("rst_grant", 32'(grant), 32'(3'b001));

      repeat (500) begin
         @(posedge clock); #1;
         drive_random();
      end
      @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
